imem_fetch_ctrl: RTL

Sequencer that owns the single port of the 64-word instruction memory and shares it between a program loader and the fetch stage. It writes a program into the memory word by word, then on `start` runs a word-addressed PC through the memory. Fetched words are handed to decode over a valid/ready handshake, with branch/jump redirect and halt detection. The block sits between the instruction memory and the decode stage of the single-cycle/pipelined core.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_load_seq.sv | 44 ++++
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch sequencer.
// Holds the controller state encoding and the default memory geometry.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int          IMEM_ADDR_W    = 6;
  localparam int          IMEM_DATA_W    = 32;
  localparam logic [31:0] IMEM_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_load_seq.sv
// Load-address counter for the program loader, with overflow detection and sticky error.
// Counter is one bit wider than the address so a full memory is distinguishable from empty.
module imem_load_seq
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              first,
  input  logic              adv,
  input  logic              clr,
  input  logic              err_set,
  output logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ovf,
  output logic              ld_err
);

  logic [ADDR_W:0] cnt;

  // Counter returns to 0 whenever a load ends so the next load starts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      ld_err <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (first)
        cnt <= (ADDR_W+1)'(1);
      else if (adv)
        cnt <= cnt + (ADDR_W+1)'(1);

      if (err_set)
        ld_err <= 1'b1;
      else if (first)
        ld_err <= 1'b0;
    end
  end

  assign ld_addr = cnt[ADDR_W-1:0];
  assign ld_ovf  = cnt[ADDR_W];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Shares the instruction-memory port between the program loader and the fetch stage.
// Fetch has one cycle of latency, redirect inserts one bubble, and halt takes priority over redirect.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = IMEM_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_ovf;
  logic              is_idle, is_load, is_run, is_halt;
  logic              accept, halt_go, fetch_en, start_run;
  logic              ld_first, ld_adv, ld_clr, ld_err_set;

  assign is_idle = (state == ST_IDLE);
  assign is_load = (state == ST_LOAD);
  assign is_run  = (state == ST_RUN);
  assign is_halt = (state == ST_HALT);

  assign accept    = if_valid && if_ready;
  assign halt_go   = is_run && (stop || (accept && (if_instr == HALT_WORD)));
  assign fetch_en  = !if_valid || if_ready;
  // A loader word in IDLE beats start.
  assign start_run = start && ((is_idle && !ld_valid) || is_halt);

  assign ld_first   = is_idle && ld_valid;
  assign ld_adv     = is_load && ld_valid && !ld_ovf;
  assign ld_err_set = is_load && ld_valid && ld_ovf;
  assign ld_clr     = (ld_valid && ld_last && (is_idle || is_load)) || ld_err_set;

  assign ld_ready   = is_idle || is_load;
  assign imem_we    = ld_first || ld_adv;
  assign imem_wdata = ld_data;
  assign imem_addr  = ld_ready ? ld_addr : pc;
  assign busy       = is_load || is_run;
  assign halted     = is_halt;

  imem_load_seq #(.ADDR_W(ADDR_W)) u_load_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .first   (ld_first),
    .adv     (ld_adv),
    .clr     (ld_clr),
    .err_set (ld_err_set),
    .ld_addr (ld_addr),
    .ld_ovf  (ld_ovf),
    .ld_err  (ld_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ld_valid)
          state_nxt = ld_last ? ST_IDLE : ST_LOAD;
        else if (start)
          state_nxt = ST_RUN;
      end
      ST_LOAD: begin
        if (ld_valid && (ld_ovf || ld_last))
          state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_go)
          state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (start)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A word flushed by redirect is not counted unless halt overrides the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (start_run) begin
      pc          <= '0;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (is_run) begin
      if (accept && (halt_go || !redirect_valid) && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;

      if (halt_go) begin
        if_valid <= 1'b0;
      end else if (redirect_valid) begin
        pc       <= redirect_pc;
        if_valid <= 1'b0;
      end else if (fetch_en) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        pc       <= pc + ADDR_W'(1);
      end
    end
  end

endmodule
